// File: rtl/detector_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package detector_pkg;

   // State encodes how many leading pattern bits have been matched so far.
   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b0110;

   // Transition table indexed by {state, x}; entries for unused encodings 5..7
   // point back into the S0 row so a corrupted state recovers on the next edge.
   typedef logic [15:0][2:0] trans_t;

   // Longest suffix of (matched prefix, x) that is also a prefix of pattern.
   // Pattern MSB is the first bit received. From S4 the matched prefix is the
   // whole pattern when overlapping, otherwise matching restarts from nothing.
   function automatic state_t next_state(input logic [3:0] pattern,
                                         input state_t     st,
                                         input logic       x,
                                         input logic       overlap);
      int k;
      int pat;
      int v;
      int best;
      k = int'(st);
      if (k > 4 || (k == 4 && !overlap)) k = 0;
      pat  = int'(pattern);
      // v holds the k matched bits followed by x, i.e. k+1 bits, newest in LSB.
      v    = ((pat >> (4 - k)) << 1) | int'(x);
      best = 0;
      for (int l = 1; l <= 4; l++) begin
         if (l <= k + 1 && ((v & ((1 << l) - 1)) == (pat >> (4 - l))))
            best = l;
      end
      return state_t'(best[2:0]);
   endfunction

   function automatic trans_t build_table(input logic [3:0] pattern,
                                          input logic       overlap);
      trans_t     t;
      logic [3:0] idx;
      t = '0;
      for (int i = 0; i < 16; i++) begin
         idx    = 4'(i);
         t[idx] = next_state(pattern, state_t'(idx[3:1]), idx[0], overlap);
      end
      return t;
   endfunction

endpackage

// File: rtl/detector.sv
// Serial 4-bit pattern detector (Moore FSM), overlapping or restart-after-match.
// Latency: z high in the cycle after the edge that samples the last pattern bit.
// Backpressure: none; one bit consumed every clk edge while reset is low.
//
// Ports:
//   x     - serial data bit, sampled on rising clk
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; forces state S0 and z low
//   z     - detection flag, decoded from the state register only
module detector
   import detector_pkg::*;
#(
   parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
   parameter bit         OVERLAP = 1'b1
) (
   input  logic x,
   input  logic clk,
   input  logic reset,
   output logic z
);

   // Whole next-state function resolved at elaboration; runtime logic is a
   // 16-entry lookup on {state, x}.
   localparam trans_t TABLE = build_table(PATTERN, OVERLAP);

   state_t state;
   state_t state_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S0;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = S0;
      z         = 1'b0;
      state_nxt = state_t'(TABLE[{state, x}]);
      z         = (state == S4);
   end

endmodule

// File: tb/tb_detector.sv
module tb_detector;
   import detector_pkg::*;

   logic       clk;
   logic       reset;
   logic       x;
   logic [3:0] z;

   // Four configurations driven by the same stream: default overlapping,
   // default non-overlapping, and two self-overlapping patterns.
   detector #(.PATTERN(4'b0110), .OVERLAP(1'b1)) dut0 (.x(x), .clk(clk), .reset(reset), .z(z[0]));
   detector #(.PATTERN(4'b0110), .OVERLAP(1'b0)) dut1 (.x(x), .clk(clk), .reset(reset), .z(z[1]));
   detector #(.PATTERN(4'b1111), .OVERLAP(1'b1)) dut2 (.x(x), .clk(clk), .reset(reset), .z(z[2]));
   detector #(.PATTERN(4'b1010), .OVERLAP(1'b0)) dut3 (.x(x), .clk(clk), .reset(reset), .z(z[3]));

   localparam logic [3:0] PAT [4] = '{4'b0110, 4'b0110, 4'b1111, 4'b1010};
   localparam bit         OVL [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a window of the last four bits plus the number of bits
   // seen since matching (re)started. A hit needs four fresh bits equal to the
   // pattern; without overlap a hit restarts the count.
   logic [3:0] win [4];
   int         cnt [4];
   logic [3:0] exp_q [$];
   logic [3:0] mon_e;

   task automatic check(input string name, input int idx, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] at %0t: got %b, expected %b", name, idx, $time, got, exp);
      end
   endtask

   // mode 0: plain bit; 1: release reset just after driving this bit;
   // 2: pulse reset mid-cycle just before this bit is sampled.
   task automatic send(input logic b, input int mode);
      logic [3:0] e;
      @(negedge clk);
      x = b;
      if (mode == 1) begin
         #1 reset = 1'b0;
      end
      if (mode == 2) begin
         #1 reset = 1'b1;
         #1;
         for (int i = 0; i < 4; i++) check("z_during_reset", i, z[i], 1'b0);
         for (int i = 0; i < 4; i++) cnt[i] = 0;
         #1 reset = 1'b0;
      end
      e = '0;
      if (reset) begin
         for (int i = 0; i < 4; i++) cnt[i] = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            win[i] = {win[i][2:0], b};
            cnt[i] = cnt[i] + 1;
            if (cnt[i] >= 4 && win[i] == PAT[i]) begin
               e[i] = 1'b1;
               if (!OVL[i]) cnt[i] = 0;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   // Bits MSB-first; the first bit is preceded by a mid-cycle reset pulse.
   task automatic send_seq(input logic [15:0] v, input int n);
      logic [15:0] t;
      for (int k = 0; k < n; k++) begin
         t = v >> (n - 1 - k);
         send(t[0], (k == 0) ? 2 : 0);
      end
   endtask

   // Monitor: one expected response per sampled edge, compared 1 time unit
   // after the edge.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         n_vec++;
         if (dut0.state !== S0) begin
            n_err++;
            $display("FAIL state_in_reset at %0t: got %0d, expected %0d", $time, dut0.state, S0);
         end
      end
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         for (int i = 0; i < 4; i++) check("z", i, z[i], mon_e[i]);
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         win[i] = '0;
         cnt[i] = 0;
      end
      reset = 1'b1;
      x     = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) check("z_reset", i, z[i], 1'b0);

      // Reset held with x toggling, then released mid-cycle, then 0110.
      send(1'b1, 0);
      send(1'b0, 0);
      send(1'b1, 0);
      send(1'b0, 1);
      send(1'b1, 0);
      send(1'b1, 0);
      send(1'b0, 0);
      send(1'b0, 0);
      send(1'b0, 0);

      send_seq(16'b01101100110, 11);   // overlap: hits after bits 4, 7, 11
      send_seq(16'b0110110, 7);        // non-overlap: single hit
      send_seq(16'b01100110, 8);       // non-overlap: hits after 4 and 8
      send_seq(16'b01110110, 8);       // near miss then hit after bit 8
      send_seq(16'b000110, 6);         // hit after bit 6
      send_seq(16'b011, 3);            // partial match ...
      send_seq(16'b00110, 5);          // ... discarded by reset, then 0110
      send_seq(16'b1111111, 7);        // self-overlapping 1111
      send_seq(16'b1010101010, 10);    // self-overlapping 1010

      for (int i = 0; i < 3000; i++)
         send(1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0) ? 2 : 0);

      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
